// File: rtl/sys_run_monitor_pkg.sv
// -----------------------------------------------------------------------------
// sys_run_monitor_pkg
//   Shared definitions for the run controller / performance monitor:
//   - run_state_t : controller state encoding (IDLE=0, HOLD=1, RUN=2, DONE=3)
//   - CH_ICACHE / CH_DCACHE : stall channel indices into the stall vector
//   - cnt_bits()  : width needed for a counter that walks 0..n-1
// -----------------------------------------------------------------------------
package sys_run_monitor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } run_state_t;

  // Stall channel assignment as wired beside the cached processor system.
  localparam int CH_ICACHE = 0;
  localparam int CH_DCACHE = 1;

  // Bits needed to hold values 0..n-1 (at least one bit).
  function automatic int cnt_bits(input int n);
    int b;
    b = 1;
    while ((1 << b) < n) b++;
    return b;
  endfunction

endpackage

// File: rtl/sys_run_monitor_sat_counter.sv
// -----------------------------------------------------------------------------
// sys_run_monitor_sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk   in  1  clock, posedge
//     clr   in  1  synchronous clear (wins over inc)
//     inc   in  1  count enable for this cycle
//     count out W  current value
// -----------------------------------------------------------------------------
module sys_run_monitor_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sys_run_monitor.sv
// -----------------------------------------------------------------------------
// sys_run_monitor
//   Run controller and performance monitor for the cached processor system.
//   Holds the CPU in reset, releases it for a run, counts run cycles, stall-free
//   cycles and per-channel stall cycles, and ends the run on a cycle budget
//   (MAX_CYCLES, 0 = unlimited) or, when built with HALT_DETECT_EN defined, on
//   HALT_WIN consecutive unchanged-PC, stall-free cycles.
//
//   Build option: `define HALT_DETECT_EN to enable halt detection. Without it
//   the pc input is ignored and only the budget ends a run.
//
//   Ports:
//     CLK          in   1             clock, posedge
//     RESET        in   1             synchronous active-high reset
//     start        in   1             run request pulse
//     pc           in   PC_W          current CPU PC (halt detection only)
//     stall        in   NUM_CH        per-channel busywait (ch0 icache, ch1 dcache)
//     cpu_reset    out  1             reset to the CPU system
//     running      out  1             high while in RUN
//     done         out  1             high in DONE
//     timeout      out  1             last run ended on the cycle budget
//     cycle_count  out  CNT_W         RUN cycles elapsed
//     active_count out  CNT_W         RUN cycles with no stall
//     stall_count  out  NUM_CH*CNT_W  channel k in bits [k*CNT_W +: CNT_W]
//
//   Handshake: start is a single-cycle request with no ready. It is accepted
//   only in IDLE or DONE (the cycle it is seen high there, the run launches and
//   all counters clear); in HOLD or RUN it is dropped without effect.
//
//   The controller state is the internal signal `state` (run_state_t).
// -----------------------------------------------------------------------------
module sys_run_monitor
  import sys_run_monitor_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int NUM_CH     = 2,
  parameter int PC_W       = 32,
  parameter int RST_HOLD   = 2,
  parameter int MAX_CYCLES = 126,
  parameter int HALT_WIN   = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    start,
  input  logic [PC_W-1:0]         pc,
  input  logic [NUM_CH-1:0]       stall,
  output logic                    cpu_reset,
  output logic                    running,
  output logic                    done,
  output logic                    timeout,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [CNT_W-1:0]        active_count,
  output logic [NUM_CH*CNT_W-1:0] stall_count
);

  localparam int               HOLD_W      = cnt_bits(RST_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RST_HOLD - 1);
  localparam bit               BUDGET_EN   = (MAX_CYCLES != 0);
  // Budget fires on the edge where cycle_count goes from MAX_CYCLES-1 to MAX_CYCLES.
  localparam logic [CNT_W-1:0] BUDGET_LAST = CNT_W'(MAX_CYCLES - 1);

  run_state_t        state;
  logic [HOLD_W-1:0] hold_cnt;

  logic run_cycle;
  logic launch;
  logic cnt_clr;
  logic no_stall;
  logic budget_hit;
  logic halt_hit;

  assign run_cycle  = (state == S_RUN);
  assign launch     = start && ((state == S_IDLE) || (state == S_DONE));
  assign cnt_clr    = RESET || launch;
  assign no_stall   = (stall == '0);
  assign budget_hit = BUDGET_EN && run_cycle && (cycle_count == BUDGET_LAST);

  // ---------------------------------------------------------------------------
  // Performance counters: only advance in RUN, so they hold through DONE.
  // ---------------------------------------------------------------------------
  sys_run_monitor_sat_counter #(.W(CNT_W)) u_cycle_ctr (
    .clk   (CLK),
    .clr   (cnt_clr),
    .inc   (run_cycle),
    .count (cycle_count)
  );

  sys_run_monitor_sat_counter #(.W(CNT_W)) u_active_ctr (
    .clk   (CLK),
    .clr   (cnt_clr),
    .inc   (run_cycle && no_stall),
    .count (active_count)
  );

  for (genvar k = 0; k < NUM_CH; k++) begin : g_stall_ctr
    sys_run_monitor_sat_counter #(.W(CNT_W)) u_stall_ctr (
      .clk   (CLK),
      .clr   (cnt_clr),
      .inc   (run_cycle && stall[k]),
      .count (stall_count[k*CNT_W +: CNT_W])
    );
  end

  // ---------------------------------------------------------------------------
  // Halt detection
  // ---------------------------------------------------------------------------
`ifdef HALT_DETECT_EN
  logic [PC_W-1:0]  pc_prev;
  logic [CNT_W-1:0] halt_count;
  logic             halt_cond;

  // Loading during HOLD makes the first RUN cycle compare against the PC the
  // CPU presents while it is still held in reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_prev <= '0;
    end else if ((state == S_HOLD) || (state == S_RUN)) begin
      pc_prev <= pc;
    end
  end

  assign halt_cond = run_cycle && no_stall && (pc == pc_prev);

  // Any RUN cycle that moves the PC or stalls restarts the window.
  sys_run_monitor_sat_counter #(.W(CNT_W)) u_halt_ctr (
    .clk   (CLK),
    .clr   (RESET || !halt_cond),
    .inc   (halt_cond),
    .count (halt_count)
  );

  assign halt_hit = halt_cond && (halt_count == CNT_W'(HALT_WIN - 1));
`else
  logic unused_halt_cfg;
  assign unused_halt_cfg = ^{pc, (HALT_WIN != 0)};
  assign halt_hit        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Controller FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      hold_cnt  <= '0;
      cpu_reset <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_HOLD;
            hold_cnt  <= '0;
            cpu_reset <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
          end
        end

        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state     <= S_RUN;
            cpu_reset <= 1'b0;
            running   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        S_RUN: begin
          // Halt takes priority when both end conditions land on one edge.
          if (halt_hit || budget_hit) begin
            state     <= S_DONE;
            cpu_reset <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b1;
            timeout   <= !halt_hit;
          end
        end

        default: begin
          state     <= S_IDLE;
          cpu_reset <= 1'b1;
          running   <= 1'b0;
          done      <= 1'b0;
          timeout   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_run_monitor.sv
// -----------------------------------------------------------------------------
// tb_sys_run_monitor
//   Directed bench for sys_run_monitor. u_dut uses the default parameters;
//   u_sat is a 4-bit, unlimited-budget instance for counter saturation.
//   Completed runs of u_dut are checked by a monitor that pops the expected
//   end-of-run result queued when the run was launched.
// -----------------------------------------------------------------------------
module tb_sys_run_monitor;
  import sys_run_monitor_pkg::*;

  localparam int RW = 1 + 4 * 32;  // {timeout, cycle, active, stall1, stall0}

  // ---------------------------------------------------------------------------
  // Clock / reset / stimulus signals
  // ---------------------------------------------------------------------------
  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic [31:0] pc;
  logic [1:0]  stall;
  logic [1:0]  stall_s;
  logic        pc_auto;

  always #5 CLK = ~CLK;

  logic        m_cpu_reset, m_running, m_done, m_timeout;
  logic [31:0] m_cycle, m_active;
  logic [63:0] m_stall;

  logic        s_cpu_reset, s_running, s_done, s_timeout;
  logic [3:0]  s_cycle, s_active;
  logic [7:0]  s_stall;

  sys_run_monitor u_dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .start        (start),
    .pc           (pc),
    .stall        (stall),
    .cpu_reset    (m_cpu_reset),
    .running      (m_running),
    .done         (m_done),
    .timeout      (m_timeout),
    .cycle_count  (m_cycle),
    .active_count (m_active),
    .stall_count  (m_stall)
  );

  sys_run_monitor #(.CNT_W(4), .MAX_CYCLES(0)) u_sat (
    .CLK          (CLK),
    .RESET        (RESET),
    .start        (start),
    .pc           (pc),
    .stall        (stall_s),
    .cpu_reset    (s_cpu_reset),
    .running      (s_running),
    .done         (s_done),
    .timeout      (s_timeout),
    .cycle_count  (s_cycle),
    .active_count (s_active),
    .stall_count  (s_stall)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] mk_exp(input logic t, input logic [31:0] c,
                                          input logic [31:0] a, input logic [31:0] s1,
                                          input logic [31:0] s0);
    return {t, c, a, s1, s0};
  endfunction

  logic [RW-1:0] cur_exp;
  logic          done_q = 1'b0;

  always @(negedge CLK) begin
    if (m_done && !done_q) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1, required no run pending (t=%0t)", $time);
      end else begin
        cur_exp = exp_q.pop_front();
        check("run_timeout", {31'd0, m_timeout}, {31'd0, cur_exp[128]});
        check("run_cycles",  m_cycle,            cur_exp[127:96]);
        check("run_active",  m_active,           cur_exp[95:64]);
        check("run_stall1",  m_stall[63:32],     cur_exp[63:32]);
        check("run_stall0",  m_stall[31:0],      cur_exp[31:0]);
      end
    end
    done_q = m_done;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Advance n edges; inputs change 1 time unit after each edge. The PC keeps
  // moving unless a test takes control of it.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      if (pc_auto) pc = pc + 32'd4;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int i;
    i = 0;
    while (!m_done && (i < limit)) begin
      tick(1);
      i++;
    end
    check("done_reached", {31'd0, m_done}, 32'd1);
  endtask

`ifdef HALT_DETECT_EN
  // pc 4, 8, then fixed at 12; optional single stall[0] pulse at RUN cycle stall_at.
  task automatic halt_run(input int stall_at, input int exp_cyc, input int exp_act,
                          input int exp_s0);
    int i;
    exp_q.push_back(mk_exp(1'b0, exp_cyc, exp_act, 32'd0, exp_s0));
    pc_auto = 1'b0;
    pc      = 32'd0;
    pulse_start();
    tick(2);
    i = 1;
    while (!m_done && (i <= 40)) begin
      pc    = (i == 1) ? 32'd4 : ((i == 2) ? 32'd8 : 32'd12);
      stall = (i == stall_at) ? 2'b01 : 2'b00;
      tick(1);
      i++;
    end
    stall = 2'b00;
    check("halt_done", {31'd0, m_done}, 32'd1);
    tick(2);
    pc_auto = 1'b1;
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    RESET   = 1'b1;
    start   = 1'b0;
    pc      = 32'd0;
    stall   = 2'b00;
    stall_s = 2'b00;
    pc_auto = 1'b1;
    tick(2);

    // Reset state
    check("rst_cpu_reset", {31'd0, m_cpu_reset}, 32'd1);
    check("rst_running",   {31'd0, m_running},   32'd0);
    check("rst_done",      {31'd0, m_done},      32'd0);
    check("rst_timeout",   {31'd0, m_timeout},   32'd0);
    check("rst_cycles",    m_cycle,              32'd0);
    check("rst_sat_cycles", {28'd0, s_cycle},    32'd0);
    RESET = 1'b0;
    tick(1);

    // Launch sequencing, start ignored in RUN, budget end with no stalls
    exp_q.push_back(mk_exp(1'b1, 32'd126, 32'd126, 32'd0, 32'd0));
    pulse_start();
    check("hold1_cpu_reset", {31'd0, m_cpu_reset}, 32'd1);
    check("hold1_running",   {31'd0, m_running},   32'd0);
    tick(1);
    check("hold2_cpu_reset", {31'd0, m_cpu_reset}, 32'd1);
    check("hold2_running",   {31'd0, m_running},   32'd0);
    tick(1);
    check("run_cpu_reset",   {31'd0, m_cpu_reset}, 32'd0);
    check("run_running",     {31'd0, m_running},   32'd1);
    check("run_first_cycles", m_cycle,             32'd0);
    tick(10);
    pulse_start();
    check("start_in_run_running", {31'd0, m_running}, 32'd1);
    check("start_in_run_cycles",  m_cycle,            32'd11);
    wait_done(200);
    tick(3);
    check("done_cpu_reset", {31'd0, m_cpu_reset}, 32'd1);
    check("done_running",   {31'd0, m_running},   32'd0);
    check("done_hold_cycles", m_cycle,            32'd126);

    // Restart from DONE with overlapping stalls on both channels
    exp_q.push_back(mk_exp(1'b1, 32'd126, 32'd114, 32'd5, 32'd10));
    pulse_start();
    check("restart_done",    {31'd0, m_done},    32'd0);
    check("restart_timeout", {31'd0, m_timeout}, 32'd0);
    check("restart_cycles",  m_cycle,            32'd0);
    check("restart_active",  m_active,           32'd0);
    tick(2);
    for (int i = 1; i <= 40; i++) begin
      stall[CH_ICACHE] = (i <= 10);
      stall[CH_DCACHE] = (i >= 8) && (i <= 12);
      tick(1);
    end
    stall = 2'b00;
    check("stall40_cycles", m_cycle,        32'd40);
    check("stall40_active", m_active,       32'd28);
    check("stall40_ch0",    m_stall[31:0],  32'd10);
    check("stall40_ch1",    m_stall[63:32], 32'd5);
    wait_done(200);
    tick(3);

    // Abort mid-run with RESET
    pulse_start();
    tick(2);
    tick(50);
    check("abort_pre_cycles", m_cycle, 32'd50);
    RESET = 1'b1;
    tick(1);
    check("abort_cpu_reset", {31'd0, m_cpu_reset}, 32'd1);
    check("abort_running",   {31'd0, m_running},   32'd0);
    check("abort_cycles",    m_cycle,              32'd0);
    check("abort_ch0",       m_stall[31:0],        32'd0);
    RESET = 1'b0;
    tick(1);

    // Saturation on the 4-bit unlimited instance; u_dut runs a clean budget run
    exp_q.push_back(mk_exp(1'b1, 32'd126, 32'd126, 32'd0, 32'd0));
    pulse_start();
    tick(2);
    stall_s = 2'b01;
    tick(20);
    stall_s = 2'b00;
    check("sat_cycles",  {28'd0, s_cycle},      32'd15);
    check("sat_ch0",     {28'd0, s_stall[3:0]}, 32'd15);
    check("sat_ch1",     {28'd0, s_stall[7:4]}, 32'd0);
    check("sat_active",  {28'd0, s_active},     32'd0);
    check("sat_running", {31'd0, s_running},    32'd1);
    wait_done(200);
    tick(3);

`ifdef HALT_DETECT_EN
    halt_run(0, 11, 11, 0);
    halt_run(7, 15, 14, 1);
`endif

    check("queue_drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
